// File: rtl/status_reg_unit.sv
// status_reg_unit
//   Producer side of the NZCV flag interface. It holds the architectural
//   status register {N,Z,C,V}, which three sources can update: flag-setting
//   ALU results from EXE, a masked direct write (MSR-style), and a one-deep
//   shadow save/restore. It also detects flag read-after-write hazards for a
//   conditional instruction sitting in ID.
//
//   Optional build macro: FLAG_FORWARD_EN
//     Defined   : status_fwd bypasses the next flag value, and flag_hazard is 0.
//     Undefined : status_fwd = status_reg, and flag_hazard requests an ID stall.
//
// Ports
//   clk, rst        : clock; synchronous active-high reset
//   freeze          : pipeline stall; holds all state
//   exe_valid/exe_s : live EXE instruction and its S bit
//   alu_status      : ALU flags {N,Z,C,V}
//   msr_we/mask/data: masked direct flag write
//   save_req        : copy status_reg into the shadow
//   restore_req     : copy the shadow into status_reg
//   id_valid/id_cond: ID instruction and its condition field
//   status_reg      : registered architectural flags
//   status_fwd      : flags that ID uses this cycle
//   flag_hazard     : ID must stall
//   spsr_valid      : the shadow holds a saved value
//   restore_err     : one-cycle pulse; restore requested with an empty shadow
module status_reg_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter logic [3:0] AL_COND     = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       exe_valid,
  input  logic       exe_s,
  input  logic [3:0] alu_status,
  input  logic       msr_we,
  input  logic [3:0] msr_mask,
  input  logic [3:0] msr_data,
  input  logic       save_req,
  input  logic       restore_req,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  output logic [3:0] status_reg,
  output logic [3:0] status_fwd,
  output logic       flag_hazard,
  output logic       spsr_valid,
  output logic       restore_err
);

  logic [3:0] flags_q, flags_d;
  logic [3:0] shadow_q, shadow_d;
  logic       spsr_valid_q, spsr_valid_d;
  logic       restore_err_q, restore_err_d;
  logic       do_restore, do_alu, pending;

  always_comb begin
    do_restore    = restore_req & spsr_valid_q;
    do_alu        = exe_valid & exe_s;
    pending       = ~freeze & (do_alu | msr_we | do_restore);

    // Only the highest-priority source wins; the others are dropped silently.
    flags_d       = flags_q;
    if (do_restore)
      flags_d = shadow_q;
    else if (do_alu)
      flags_d = alu_status;
    else if (msr_we)
      flags_d = (msr_mask & msr_data) | (~msr_mask & flags_q);

    // A save in the same cycle as a restore: the restore has already taken the
    // old shadow, so the shadow is refilled from the current flags and stays valid.
    shadow_d      = shadow_q;
    spsr_valid_d  = spsr_valid_q;
    if (do_restore)
      spsr_valid_d = 1'b0;
    if (save_req) begin
      shadow_d     = flags_q;
      spsr_valid_d = 1'b1;
    end

    restore_err_d = restore_req & ~spsr_valid_q;
  end

  // Register stage: the architectural state
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q       <= RESET_FLAGS;
      shadow_q      <= RESET_FLAGS;
      spsr_valid_q  <= 1'b0;
      restore_err_q <= 1'b0;
    end else if (freeze) begin
      restore_err_q <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      shadow_q      <= shadow_d;
      spsr_valid_q  <= spsr_valid_d;
      restore_err_q <= restore_err_d;
    end
  end

  assign status_reg  = flags_q;
  assign spsr_valid  = spsr_valid_q;
  assign restore_err = restore_err_q;

`ifdef FLAG_FORWARD_EN
  // Bypass: ID sees the value status_reg will take at the next edge.
  assign status_fwd  = pending ? flags_d : flags_q;
  assign flag_hazard = 1'b0;
`else
  logic id_uses_flags;
  // Conditions AL and 1111 never read the flags, so they never stall.
  assign id_uses_flags = id_valid & (id_cond != AL_COND) & (id_cond != 4'b1111);
  assign status_fwd    = flags_q;
  assign flag_hazard   = id_uses_flags & pending;
`endif

endmodule

// File: tb/tb_status_reg_unit.sv
module tb_status_reg_unit;

  logic       clk = 1'b0;
  logic       rst, freeze, exe_valid, exe_s, msr_we, save_req, restore_req, id_valid;
  logic [3:0] alu_status, msr_mask, msr_data, id_cond;
  logic [3:0] status_reg, status_fwd;
  logic       flag_hazard, spsr_valid, restore_err;

  status_reg_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .exe_valid(exe_valid), .exe_s(exe_s),
    .alu_status(alu_status), .msr_we(msr_we), .msr_mask(msr_mask), .msr_data(msr_data),
    .save_req(save_req), .restore_req(restore_req), .id_valid(id_valid), .id_cond(id_cond),
    .status_reg(status_reg), .status_fwd(status_fwd), .flag_hazard(flag_hazard),
    .spsr_valid(spsr_valid), .restore_err(restore_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_flags, m_shadow;
  bit         m_sv, m_err, m_init;

  function automatic bit m_pending();
    return !freeze && ((exe_valid && exe_s) || msr_we || (restore_req && m_sv));
  endfunction

  function automatic logic [3:0] m_next();
    logic [3:0] r;
    r = m_flags;
    if (restore_req && m_sv) r = m_shadow;
    else if (exe_valid && exe_s) r = alu_status;
    else if (msr_we)
      for (int i = 0; i < 4; i++) if (msr_mask[i]) r[i] = msr_data[i];
    return r;
  endfunction

  function automatic logic [3:0] m_fwd();
`ifdef FLAG_FORWARD_EN
    return m_pending() ? m_next() : m_flags;
`else
    return m_flags;
`endif
  endfunction

  function automatic logic m_haz();
`ifdef FLAG_FORWARD_EN
    return 1'b0;
`else
    return id_valid && id_cond != 4'b1110 && id_cond != 4'b1111 && m_pending();
`endif
  endfunction

  task automatic m_step();
    logic [3:0] nf, ns;
    bit nsv;
    if (rst) begin
      m_flags = 4'b0000; m_shadow = 4'b0000; m_sv = 0; m_err = 0; m_init = 1;
    end else if (freeze) begin
      m_err = 0;
    end else begin
      nf = m_next(); ns = m_shadow; nsv = m_sv;
      if (restore_req && m_sv) nsv = 0;
      if (save_req) begin ns = m_flags; nsv = 1; end
      m_err = restore_req && !m_sv;
      m_flags = nf; m_shadow = ns; m_sv = nsv;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, frz, ev, es; logic [3:0] alu;
    logic mw; logic [3:0] mm, md;
    logic sv, rs, idv; logic [3:0] idc;
    logic [3:0] e_st; logic e_spsr, e_err, e_haz;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic r, f, ev, es, input logic [3:0] alu,
                              input logic mw, input logic [3:0] mm, md,
                              input logic sv, rs, idv, input logic [3:0] idc,
                              input logic [3:0] e_st, input logic e_spsr, e_err, e_haz);
    vec_t v;
    v.rst = r; v.frz = f; v.ev = ev; v.es = es; v.alu = alu;
    v.mw = mw; v.mm = mm; v.md = md; v.sv = sv; v.rs = rs; v.idv = idv; v.idc = idc;
    v.e_st = e_st; v.e_spsr = e_spsr; v.e_err = e_err; v.e_haz = e_haz;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; freeze = v.frz; exe_valid = v.ev; exe_s = v.es; alu_status = v.alu;
    msr_we = v.mw; msr_mask = v.mm; msr_data = v.md; save_req = v.sv; restore_req = v.rs;
    id_valid = v.idv; id_cond = v.idc;
  endtask

  task automatic check_comb_model(input string tag);
    if (m_init) begin
      check({tag, "_fwd"}, status_fwd, m_fwd());
      check({tag, "_haz"}, {3'b0, flag_hazard}, {3'b0, m_haz()});
    end
  endtask

  task automatic check_regs_model(input string tag);
    check({tag, "_status"}, status_reg, m_flags);
    check({tag, "_spsr"}, {3'b0, spsr_valid}, {3'b0, m_sv});
    check({tag, "_err"}, {3'b0, restore_err}, {3'b0, m_err});
  endtask

  logic exp_haz;

  initial begin
    m_init = 0; m_flags = 4'b0; m_shadow = 4'b0; m_sv = 0; m_err = 0;
    //            rst frz ev es alu     mw mask    data    sv rs idv cond     st      spsr err haz
    tbl[0]  = mk(1, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 1, 4'b1010, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b1010, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 4'b0110, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b1010, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 4'b0000, 1, 4'b0011, 4'b0101, 0, 0, 0, 4'b0000, 4'b1001, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 1, 4'b0110, 1, 4'b0011, 4'b0101, 0, 0, 0, 4'b0000, 4'b0110, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 4'b0000, 1, 4'b1111, 4'b1001, 0, 0, 0, 4'b0000, 4'b1001, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b1001, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b1001, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b1001, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b1001, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 1, 4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0100, 0, 0, 1);
    tbl[14] = mk(0, 0, 1, 1, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 1, 4'b1110, 4'b1111, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, 0, 1, 4'b1111, 4'b0000, 0, 0, 0);
    tbl[16] = mk(0, 0, 1, 1, 4'b0011, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001, 4'b0011, 0, 0, 0);
    tbl[17] = mk(0, 1, 1, 1, 4'b1100, 0, 4'b0000, 4'b0000, 1, 0, 1, 4'b0000, 4'b0011, 0, 0, 0);
    tbl[18] = mk(1, 1, 1, 1, 4'b1100, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[19] = mk(0, 1, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 4'b0000, 1, 4'b1111, 4'b0101, 0, 0, 0, 4'b0000, 4'b0101, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0101, 1, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b1111, 1, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 1, 0, 4'b0000, 4'b0101, 1, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b1111, 0, 0, 0);
    tbl[25] = mk(0, 0, 1, 1, 4'b0110, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b0110, 0, 1, 0);
    tbl[26] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0110, 1, 0, 0);
    tbl[27] = mk(0, 0, 1, 1, 4'b1000, 0, 4'b0000, 4'b0000, 0, 1, 1, 4'b0000, 4'b0110, 0, 0, 1);

    drive(tbl[0]);
    @(posedge clk); #1;

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i]);
      @(negedge clk);
`ifdef FLAG_FORWARD_EN
      exp_haz = 1'b0;
`else
      exp_haz = tbl[i].e_haz;
`endif
      if (m_init) begin
        check($sformatf("vec%0d_haz", i), {3'b0, flag_hazard}, {3'b0, exp_haz});
        check($sformatf("vec%0d_fwd", i), status_fwd, m_fwd());
      end
      @(posedge clk);
      m_step();
      #1;
      check($sformatf("vec%0d_status", i), status_reg, tbl[i].e_st);
      check($sformatf("vec%0d_spsr", i), {3'b0, spsr_valid}, {3'b0, tbl[i].e_spsr});
      check($sformatf("vec%0d_err", i), {3'b0, restore_err}, {3'b0, tbl[i].e_err});
    end

    // Hand sequence: ALU update pending while a conditional sits in ID (flags 0110).
    drive(mk(0, 0, 1, 1, 4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0, 0, 0, 0));
    @(negedge clk);
`ifdef FLAG_FORWARD_EN
    check("fwd_alu_val", status_fwd, 4'b0100);
    check("fwd_alu_haz", {3'b0, flag_hazard}, 4'b0000);
`else
    check("fwd_alu_val", status_fwd, 4'b0110);
    check("fwd_alu_haz", {3'b0, flag_hazard}, 4'b0001);
`endif
    @(posedge clk); m_step(); #1;
    check("fwd_alu_status", status_reg, 4'b0100);

    // Masked MSR pending: 0100 with mask 1100 and data 1000 gives 1000.
    drive(mk(0, 0, 0, 0, 4'b0000, 1, 4'b1100, 4'b1000, 0, 0, 1, 4'b0101, 4'b0, 0, 0, 0));
    @(negedge clk);
`ifdef FLAG_FORWARD_EN
    check("fwd_msr_val", status_fwd, 4'b1000);
    check("fwd_msr_haz", {3'b0, flag_hazard}, 4'b0000);
`else
    check("fwd_msr_val", status_fwd, 4'b0100);
    check("fwd_msr_haz", {3'b0, flag_hazard}, 4'b0001);
`endif
    @(posedge clk); m_step(); #1;
    check("fwd_msr_status", status_reg, 4'b1000);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom % 40) == 0;
      freeze      = ($urandom % 5) == 0;
      exe_valid   = $urandom % 2;
      exe_s       = $urandom % 2;
      alu_status  = 4'($urandom);
      msr_we      = ($urandom % 3) == 0;
      msr_mask    = 4'($urandom);
      msr_data    = 4'($urandom);
      save_req    = ($urandom % 4) == 0;
      restore_req = ($urandom % 4) == 0;
      id_valid    = $urandom % 2;
      id_cond     = ($urandom % 3 == 0) ? 4'(4'hE + ($urandom % 2)) : 4'($urandom);
      @(negedge clk);
      check_comb_model($sformatf("rnd%0d", c));
      @(posedge clk);
      m_step();
      #1;
      check_regs_model($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/status_reg_unit.md
Name: status_reg_unit

Overview:
- Producer side of the NZCV flag interface. Holds the architectural status register that the condition checker consumes as status_reg[3:0] ({N,Z,C,V}).
- Sources of updates: flag-setting ALU results (S bit) from EXE, a masked direct write (MSR-style), and a one-deep shadow save/restore.
- Detects read-after-write flag hazards for a conditional instruction sitting in ID.

Parameters:
RESET_FLAGS, 4'b0000, value loaded into status_reg and shadow on reset
AL_COND, 4'b1110, condition code meaning "always"; 4'b1111 is also treated as flag-independent

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
freeze  input  1  pipeline stall; holds all state when 1
exe_valid  input  1  EXE stage holds a live (not flushed) instruction
exe_s  input  1  S bit of the EXE instruction
alu_status  input  4  {N,Z,C,V} produced by the ALU this cycle
msr_we  input  1  direct flag write request
msr_mask  input  4  per-flag write enable, bit order {N,Z,C,V}
msr_data  input  4  direct write data
save_req  input  1  copy status_reg into shadow
restore_req  input  1  copy shadow into status_reg
id_valid  input  1  ID stage holds a live instruction
id_cond  input  4  condition field of the ID instruction
status_reg  output  4  registered architectural flags {N,Z,C,V}
status_fwd  output  4  flags the ID stage must use this cycle
flag_hazard  output  1  ID must stall; flags not yet available
spsr_valid  output  1  shadow holds a saved value
restore_err  output  1  one-cycle registered pulse: restore requested with empty shadow

Behaviour:
- Reset (rst=1 at edge):
  - status_reg and shadow load RESET_FLAGS.
  - spsr_valid=0 and restore_err=0.
  - Reset overrides freeze and every request.
- freeze=1: status_reg, shadow and spsr_valid hold; restore_err is cleared to 0; all requests are ignored, not queued.
- Next-value priority when not frozen, highest first:
  1. restore_req with spsr_valid=1: next = shadow; spsr_valid <= 0.
  2. exe_valid & exe_s: next = alu_status.
  3. msr_we: next[i] = msr_mask[i] ? msr_data[i] : status_reg[i].
  4. Otherwise hold.
- A lower-priority request colliding with a higher one is dropped. No error is raised for the drop.
- restore_req with spsr_valid=0:
  - status_reg is not touched by the restore; the lower priorities still apply.
  - restore_err <= 1 for exactly one cycle, and is 0 otherwise.
- save_req:
  - shadow <= status_reg (the current registered value, not next) and spsr_valid <= 1.
  - Save with spsr_valid=1 overwrites the shadow.
  - Save and restore in the same cycle: restore uses the old shadow, then the shadow loads the current status_reg and spsr_valid ends at 1.
- Update latency: status_reg changes on the edge after the request cycle (1 cycle).
- id_uses_flags = id_valid & (id_cond != AL_COND) & (id_cond != 4'b1111).
- pending = (exe_valid & exe_s) | msr_we | (restore_req & spsr_valid), gated by ~freeze.
- Without the feature macro:
  - status_fwd = status_reg.
  - flag_hazard = id_uses_flags & pending, combinational.
- status_reg never holds X after reset. All widths are exactly 4; no arithmetic.

Optional Feature:
FLAG_FORWARD_EN
- Defined:
  - status_fwd = the computed next value (bypass) whenever pending, else status_reg.
  - flag_hazard is tied to 0.
- Undefined: behaviour exactly as in Behaviour (no bypass, stall via flag_hazard).
- The registered status_reg timing is identical in both builds.

Test Plan:
- rst=1 for 2 cycles, then release -> status_reg=0000, spsr_valid=0, restore_err=0, flag_hazard=0.
- exe_valid=1, exe_s=1, alu_status=1010 for 1 cycle -> status_reg=1010 the next cycle. Same with exe_s=0 -> status_reg unchanged.
- status_reg=1010; msr_we=1, mask=0011, data=0101 -> status_reg=1001. Same cycle with exe_s update alu_status=0110 -> status_reg=0110 (MSR dropped).
- Shadow sequence:
  - save at status_reg=1001 -> spsr_valid=1.
  - Write flags to 0000, then restore -> status_reg=1001, spsr_valid=0.
  - Second restore -> restore_err=1 for exactly one cycle, status_reg=1001.
- Hazard stimulus: id_valid=1, id_cond=0000, exe_s update pending with alu_status=0100.
  - Without macro: flag_hazard=1, status_fwd=old value.
  - With FLAG_FORWARD_EN: flag_hazard=0, status_fwd=0100.
  - id_cond=1110: flag_hazard=0.
- freeze=1 with exe_s update and save_req -> status_reg and spsr_valid unchanged. rst asserted during freeze -> reset values next cycle.
